pbpix_zskip: RTL and testbench

PBPIX_ZSKIP -- requirements
Module: pbpix_zskip

---
 rtl/pbpix_zskip.sv | 108 ++++++++++
 tb/tb_pbpix_zskip.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbpix_zskip.sv
// pbpix_zskip: zero-skipping compressor for a pbpix pixel stream.
// Non-zero pixels are forwarded with their column index. Zero pixels are
// dropped, except that a zero pixel closing a row becomes an empty row
// terminator. Output is buffered in a 2-entry FIFO.
module pbpix_zskip #(
  parameter  int DW      = 8,
  parameter  int ROW_LEN = 16,
  localparam int IW      = $clog2(ROW_LEN)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          in_rdy,
  output logic          in_ack,
  input  logic          in_zero,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_rdy,
  input  logic          out_ack,
  output logic          out_zero,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  logic [1:0]    r_cnt;
  logic          r_wptr;
  logic          r_rptr;
  logic [IW-1:0] r_col;

  logic [DW-1:0] r_mem_data [2];
  logic [IW-1:0] r_mem_idx  [2];
  logic          r_mem_last [2];
  logic          r_mem_zero [2];

  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_col_wrap;

  // Handshake and push/pop decode. A zero pixel that does not close a row
  // never touches the FIFO, so it can be consumed even when the FIFO is full.
  always_comb begin
    in_ack     = (r_cnt != 2'd2) || (in_zero && !in_last);
    w_acc      = in_rdy && in_ack;
    w_push     = w_acc && (!in_zero || in_last);
    w_pop      = out_rdy && out_ack;
    w_col_wrap = in_last || (r_col == IW'(ROW_LEN - 1));
  end

  // Column counter: advances on every accepted pixel, wraps at row end.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_col <= '0;
    end else if (w_acc) begin
      r_col <= w_col_wrap ? '0 : r_col + IW'(1);
    end
  end

  // FIFO storage write; terminator entries carry zero data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
        r_mem_last[i] <= 1'b0;
        r_mem_zero[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_mem_data[r_wptr] <= in_zero ? '0 : in_data;
      r_mem_idx[r_wptr]  <= r_col;
      r_mem_last[r_wptr] <= in_last;
      r_mem_zero[r_wptr] <= in_zero;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop holds the count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head-of-FIFO presentation; outputs read as zero whenever the FIFO is empty.
  always_comb begin
    out_rdy  = (r_cnt != '0);
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    out_zero = 1'b0;
    if (out_rdy) begin
      out_data = r_mem_data[r_rptr];
      out_idx  = r_mem_idx[r_rptr];
      out_last = r_mem_last[r_rptr];
      out_zero = r_mem_zero[r_rptr];
    end
  end

endmodule

// File: tb/tb_pbpix_zskip.sv
// Bench for pbpix_zskip: queue-based reference model checked every cycle,
// directed row scenarios with literal expectations, then random traffic.
module tb_pbpix_zskip;

  localparam int DW      = 8;
  localparam int ROW_LEN = 16;
  localparam int IW      = $clog2(ROW_LEN);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] idx;
    logic          last;
    logic          zero;
  } ent_t;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          in_rdy;
  logic          in_ack;
  logic          in_zero;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_rdy;
  logic          out_ack;
  logic          out_zero;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  pbpix_zskip #(.DW(DW), .ROW_LEN(ROW_LEN)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .in_rdy   (in_rdy),
    .in_ack   (in_ack),
    .in_zero  (in_zero),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_rdy  (out_rdy),
    .out_ack  (out_ack),
    .out_zero (out_zero),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  initial forever #5 i_clk = ~i_clk;

  int   n_checks = 0;
  int   n_err    = 0;
  ent_t mq[$];   // model FIFO contents
  int   mcol;    // model column
  ent_t lg[$];   // entries the DUT actually handed downstream

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int d, input int idx, input bit last, input bit zero);
    ent_t e;
    e.d = DW'(d); e.idx = IW'(idx); e.last = last; e.zero = zero;
    return e;
  endfunction

  function automatic ent_t lg_get(input int i);
    ent_t e;
    e = '1;
    if (i < lg.size()) e = lg[i];
    return e;
  endfunction

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge i_clk) begin
    ent_t cur;
    bit   exp_ack, acc;
    cur = '{d: out_data, idx: out_idx, last: out_last, zero: out_zero};
    if (!i_rstn) begin
      mq.delete();
      mcol = 0;
      chk("reset_outputs", 32'({out_rdy, cur}), 32'd0);
    end else begin
      exp_ack = (mq.size() < 2) || (in_zero && !in_last);
      chk("in_ack", 32'(in_ack), 32'(exp_ack));
      chk("out_rdy", 32'(out_rdy), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_head", 32'(cur), 32'(mq[0]));
      if (out_rdy && out_ack) lg.push_back(cur);
      if (mq.size() != 0 && out_ack) void'(mq.pop_front());
      acc = in_rdy && exp_ack;
      if (acc) begin
        if (!in_zero)     mq.push_back(mk(in_data, mcol, in_last, 1'b0));
        else if (in_last) mq.push_back(mk(0, mcol, 1'b1, 1'b1));
        mcol = (in_last || mcol == ROW_LEN - 1) ? 0 : mcol + 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic send(input bit z, input int d, input bit l);
    bit a;
    in_rdy = 1'b1; in_zero = z; in_data = DW'(d); in_last = l;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      a = in_ack;
      tick();
      if (a) begin
        in_rdy = 1'b0;
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL send_timeout: got no in_ack expected in_ack within 64 cycles");
    in_rdy = 1'b0;
  endtask

  task automatic rst_pulse();
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    tick();
  endtask

  initial begin
    i_rstn = 1'b0; in_rdy = 1'b0; in_zero = 1'b0; in_data = '0;
    in_last = 1'b0; out_ack = 1'b0;
    repeat (2) tick();
    i_rstn = 1'b1;
    tick();

    // Sparse row: 5,0,0,7
    out_ack = 1'b1;
    lg.delete();
    send(0, 5, 0); send(1, 0, 0); send(1, 0, 0); send(0, 7, 1);
    repeat (4) tick();
    chk("r035_count", 32'(lg.size()), 32'd2);
    chk("r035_e0", 32'(lg_get(0)), 32'(mk(5, 0, 0, 0)));
    chk("r035_e1", 32'(lg_get(1)), 32'(mk(7, 3, 1, 0)));

    // All-zero row -> single terminator
    lg.delete();
    send(1, 8'h5a, 0); send(1, 8'h5a, 0); send(1, 8'h5a, 1);
    repeat (4) tick();
    chk("r036_count", 32'(lg.size()), 32'd1);
    chk("r036_e0", 32'(lg_get(0)), 32'(mk(0, 2, 1, 1)));

    // Backpressure with 3 non-zero pixels
    out_ack = 1'b0;
    lg.delete();
    send(0, 8'h11, 0); send(0, 8'h22, 0);
    in_rdy = 1'b1; in_zero = 1'b0; in_data = 8'h33; in_last = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("r037_blocked_ack", 32'(in_ack), 32'd0);
      chk("r037_stable_data", 32'(out_data), 32'h11);
      chk("r037_stable_idx", 32'(out_idx), 32'd0);
    end
    tick();
    out_ack = 1'b1;
    send(0, 8'h33, 1);
    repeat (4) tick();
    chk("r037_count", 32'(lg.size()), 32'd3);
    chk("r037_e0", 32'(lg_get(0)), 32'(mk(8'h11, 0, 0, 0)));
    chk("r037_e1", 32'(lg_get(1)), 32'(mk(8'h22, 1, 0, 0)));
    chk("r037_e2", 32'(lg_get(2)), 32'(mk(8'h33, 2, 1, 0)));

    // Continuous stream without in_last, column wraps at ROW_LEN
    rst_pulse();
    out_ack = 1'b1;
    lg.delete();
    for (int i = 0; i < 20; i++) begin
      in_rdy = 1'b1; in_zero = 1'b0; in_data = DW'(i + 1); in_last = 1'b0;
      tick();
    end
    in_rdy = 1'b0;
    repeat (3) tick();
    chk("r038_count", 32'(lg.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      chk("r038_entry", 32'(lg_get(i)), 32'(mk(i + 1, i % ROW_LEN, 0, 0)));

    // Zeros consumed while FIFO is full
    rst_pulse();
    out_ack = 1'b0;
    lg.delete();
    send(0, 8'ha1, 0); send(0, 8'hb2, 0);
    for (int i = 0; i < 3; i++) begin
      in_rdy = 1'b1; in_zero = 1'b1; in_data = 8'hff; in_last = 1'b0;
      @(negedge i_clk);
      chk("r039_zero_ack", 32'(in_ack), 32'd1);
      chk("r039_head_data", 32'(out_data), 32'ha1);
      tick();
    end
    in_rdy = 1'b0;
    out_ack = 1'b1;
    send(0, 8'hc3, 1);
    repeat (4) tick();
    chk("r039_count", 32'(lg.size()), 32'd3);
    chk("r039_e0", 32'(lg_get(0)), 32'(mk(8'ha1, 0, 0, 0)));
    chk("r039_e1", 32'(lg_get(1)), 32'(mk(8'hb2, 1, 0, 0)));
    chk("r039_e2", 32'(lg_get(2)), 32'(mk(8'hc3, 5, 1, 0)));

    // Reset mid-row after 2 pushes
    out_ack = 1'b0;
    send(0, 8'h01, 0); send(0, 8'h02, 0);
    @(negedge i_clk);
    chk("r040_pre_rdy", 32'(out_rdy), 32'd1);
    tick();
    i_rstn = 1'b0;
    #1;
    chk("r040_rdy_async", 32'(out_rdy), 32'd0);
    tick();
    i_rstn = 1'b1;
    tick();
    out_ack = 1'b1;
    lg.delete();
    send(0, 8'h44, 1);
    repeat (3) tick();
    chk("r040_count", 32'(lg.size()), 32'd1);
    chk("r040_e0", 32'(lg_get(0)), 32'(mk(8'h44, 0, 1, 0)));

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      i_rstn  = ($urandom_range(0, 499) != 0);
      in_rdy  = ($urandom_range(0, 3) != 0);
      in_zero = ($urandom_range(0, 2) == 0);
      in_last = ($urandom_range(0, 9) == 0);
      in_data = DW'($urandom);
      out_ack = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_rstn = 1'b1;
    in_rdy = 1'b0;
    out_ack = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
